// File: rtl/pdm_decimator.sv
`default_nettype none
// =============================================================================
// Module   : pdm_decimator
// Purpose  : Drives the PDM mic bit clock, samples the mic stream, and decimates
//            it through a 4th-order CIC to saturated signed 16-bit PCM.
//            Define PDM_DCBLOCK_EN to add a first-order DC blocker on the output.
// Revision : 1.0 - initial release
// =============================================================================
module pdm_decimator #(
  parameter int CLK_DIV = 32,
  parameter int DECIM   = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               pdm_in,
  output logic               mic_clk_out,
  output logic signed [15:0] sample_out,
  output logic               sample_valid_out
);

  localparam int L     = $clog2(DECIM);
  localparam int W     = 4 * L + 2;
  localparam int SHIFT = 4 * L - 15;
  localparam int CW    = $clog2(CLK_DIV);

  localparam logic [CW-1:0]       CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]       CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [L-1:0]        DCNT_LAST = L'(DECIM - 1);
  localparam logic signed [W-1:0] S_MAX     = W'(32767);
  localparam logic signed [W-1:0] S_MIN     = W'(-32768);
  localparam logic signed [W-1:0] X_POS     = W'(1);
  localparam logic signed [W-1:0] X_NEG     = W'(-1);

  function automatic logic signed [15:0] sat_w(input logic signed [W-1:0] v);
    if (v > S_MAX)      return 16'sh7fff;
    else if (v < S_MIN) return -16'sh8000;
    else                return v[15:0];
  endfunction

  // Divider, synchronizer and frame counter
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mic_clk_q, mic_clk_d;
  logic [1:0]    sync_q, sync_d;
  logic [L-1:0]  dcnt_q, dcnt_d;
  logic          bit_stb;
  logic          frame_stb;
  logic signed [W-1:0] x_val;

  // CIC datapath
  logic signed [W-1:0] integ_q [4];
  logic signed [W-1:0] integ_d [4];
  logic signed [W-1:0] dly_q [4];
  logic signed [W-1:0] dly_d [4];
  logic signed [W-1:0] comb_v [4];
  logic signed [W-1:0] c_q, c_d;
  logic                comb_en_q, comb_en_d;
  logic                c_vld_q, c_vld_d;
  logic signed [15:0]  s_sat;

  // Output register
  logic signed [15:0]  sample_q, sample_d;
  logic                valid_q, valid_d;

`ifdef PDM_DCBLOCK_EN
  localparam logic signed [19:0] Y_MAX   = 20'sd131071;
  localparam logic signed [19:0] Y_MIN   = -20'sd131072;
  localparam logic signed [17:0] Y16_MAX = 18'sd32767;
  localparam logic signed [17:0] Y16_MIN = -18'sd32768;

  logic signed [15:0] s_q, s_d;
  logic               s_vld_q, s_vld_d;
  logic signed [15:0] s_prev_q, s_prev_d;
  logic signed [17:0] y_q, y_d;
  logic signed [19:0] dc_sum;
  logic signed [17:0] y_sat;
  logic signed [15:0] y_out;
`endif

  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    mic_clk_d = (cnt_d >= CNT_HALF);
    sync_d    = {sync_q[0], pdm_in};

    bit_stb   = (cnt_q == CNT_LAST);
    frame_stb = bit_stb && (dcnt_q == DCNT_LAST);
    dcnt_d    = bit_stb ? dcnt_q + 1'b1 : dcnt_q;
    x_val     = sync_q[1] ? X_POS : X_NEG;

    // Each stage adds the previous stage's pre-update value; wrap is exact modulo 2^W
    integ_d[0] = bit_stb ? integ_q[0] + x_val : integ_q[0];
    for (int k = 1; k < 4; k++) begin
      integ_d[k] = bit_stb ? integ_q[k] + integ_q[k-1] : integ_q[k];
    end

    comb_v[0] = integ_q[3] - dly_q[0];
    dly_d[0]  = comb_en_q ? integ_q[3] : dly_q[0];
    for (int k = 1; k < 4; k++) begin
      comb_v[k] = comb_v[k-1] - dly_q[k];
      dly_d[k]  = comb_en_q ? comb_v[k-1] : dly_q[k];
    end

    comb_en_d = frame_stb;
    c_d       = comb_en_q ? comb_v[3] : c_q;
    c_vld_d   = comb_en_q;
    s_sat     = sat_w(c_q >>> SHIFT);

`ifdef PDM_DCBLOCK_EN
    s_d     = c_vld_q ? s_sat : s_q;
    s_vld_d = c_vld_q;

    dc_sum = 20'(s_q) - 20'(s_prev_q) + 20'(y_q) - 20'(y_q >>> 8);
    if (dc_sum > Y_MAX)      y_sat = Y_MAX[17:0];
    else if (dc_sum < Y_MIN) y_sat = Y_MIN[17:0];
    else                     y_sat = dc_sum[17:0];

    if (y_sat > Y16_MAX)      y_out = 16'sh7fff;
    else if (y_sat < Y16_MIN) y_out = -16'sh8000;
    else                      y_out = y_sat[15:0];

    y_d      = s_vld_q ? y_sat : y_q;
    s_prev_d = s_vld_q ? s_q : s_prev_q;
    sample_d = s_vld_q ? y_out : sample_q;
    valid_d  = s_vld_q;
`else
    sample_d = c_vld_q ? s_sat : sample_q;
    valid_d  = c_vld_q;
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      mic_clk_q <= 1'b0;
      sync_q    <= '0;
      dcnt_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      c_q       <= '0;
      comb_en_q <= 1'b0;
      c_vld_q   <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
`ifdef PDM_DCBLOCK_EN
      s_q       <= '0;
      s_vld_q   <= 1'b0;
      s_prev_q  <= '0;
      y_q       <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      mic_clk_q <= mic_clk_d;
      sync_q    <= sync_d;
      dcnt_q    <= dcnt_d;
      for (int k = 0; k < 4; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
      c_q       <= c_d;
      comb_en_q <= comb_en_d;
      c_vld_q   <= c_vld_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
`ifdef PDM_DCBLOCK_EN
      s_q       <= s_d;
      s_vld_q   <= s_vld_d;
      s_prev_q  <= s_prev_d;
      y_q       <= y_d;
`endif
    end
  end

  assign mic_clk_out      = mic_clk_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_decimator.sv
`default_nettype none
// =============================================================================
// Module   : tb_pdm_decimator
// Purpose  : Scoreboard bench for pdm_decimator using directed PDM patterns.
// Revision : 1.0 - initial release
// =============================================================================
module tb_pdm_decimator;

  localparam int CLK_DIV = 32;
  localparam int DECIM   = 64;
  localparam int FRAME   = CLK_DIV * DECIM;
`ifdef PDM_DCBLOCK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam int K_ANY = 0;
  localparam int K_EQ  = 1;
  localparam int K_GT  = 2;
  localparam int K_LT  = 3;
  localparam int K_DEC = 4;
  localparam int K_INC = 5;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  exp_t exp_q[$];

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               pdm_in = 1'b0;
  logic               mic_clk_out;
  logic signed [15:0] sample_out;
  logic               sample_valid_out;

  logic [3:0] pat  = 4'b1111;
  logic [1:0] bidx = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;

  pdm_decimator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pdm_in           (pdm_in),
    .mic_clk_out      (mic_clk_out),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out)
  );

  always #5 clk_in = ~clk_in;

  // Mic model: presents the next pattern bit on each rising bit-clock edge
  always @(posedge mic_clk_out) begin
    pdm_in = pat[bidx];
    bidx   = bidx + 2'd1;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_rel(input string name, input bit ok, input int act, input int lim);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, limit %0d", name, act, lim);
    end
  endtask

  // Monitor: pops expectations on each valid pulse, checks timing too
  int   cyc         = 0;
  int   prev_cyc    = 0;
  int   since_fall  = 0;
  int   last_sample = 0;
  int   cur         = 0;
  bit   have_prev   = 1'b0;
  bit   prev_mic    = 1'b0;
  exp_t mon_e;

  always @(posedge clk_in) begin
    #1;
    cyc++;
    if (rst_in) begin
      have_prev  = 1'b0;
      prev_mic   = 1'b0;
      since_fall = 0;
    end else begin
      if (prev_mic && !mic_clk_out) since_fall = 0;
      else                          since_fall++;
      prev_mic = mic_clk_out;
      if (sample_valid_out) begin
        cur = int'(sample_out);
        check("valid_latency", since_fall, LAT);
        if (have_prev) check("valid_spacing", cyc - prev_cyc, FRAME);
        have_prev = 1'b1;
        prev_cyc  = cyc;
        check("expected_entry_available", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          case (mon_e.kind)
            K_EQ:  check("sample_eq", cur, mon_e.val);
            K_GT:  check_rel("sample_gt", cur > mon_e.val, cur, mon_e.val);
            K_LT:  check_rel("sample_lt", cur < mon_e.val, cur, mon_e.val);
            K_DEC: check_rel("sample_decreasing", cur < last_sample, cur, last_sample);
            K_INC: check_rel("sample_increasing", cur > last_sample, cur, last_sample);
            default: ;
          endcase
        end
        last_sample = cur;
      end
    end
  end

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_frames(input int k1, input int v1, input int k2, input int v2);
    for (int i = 0; i < 4; i++) push(K_ANY, 0);
    push(k1, v1);
    push(k2, v2);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 * FRAME && exp_q.size() > 0; i++) begin
      @(posedge clk_in);
      #2;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic run_pattern(input logic [3:0] p, input string name,
                             input int k1, input int v1, input int k2, input int v2);
    pat = p;
    do_reset();
    push_frames(k1, v1, k2, v2);
    drain(name);
  endtask

  initial begin
    int n;
    // Reset state and bit-clock waveform
    rst_in = 1'b1;
    pat    = 4'b1111;
    repeat (4) @(negedge clk_in);
    check("rst_mic_clk", int'(mic_clk_out), 0);
    check("rst_sample", int'(sample_out), 0);
    check("rst_valid", int'(sample_valid_out), 0);
    rst_in = 1'b0;
`ifdef PDM_DCBLOCK_EN
    push_frames(K_GT, 16000, K_DEC, 0);
`else
    push_frames(K_EQ, 32767, K_EQ, 32767);
`endif
    for (int i = 1; i <= 2 * CLK_DIV; i++) begin
      @(posedge clk_in);
      #1;
      check("mic_clk_phase", int'(mic_clk_out), ((i % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0);
    end
    drain("drain_const1");

    // Asynchronous reset ~30 bits into a frame, mic clock high at that point
    repeat (30 * CLK_DIV + 20) @(posedge clk_in);
    #2;
    check("pre_rst_mic_clk_high", int'(mic_clk_out), 1);
    rst_in = 1'b1;
    #1;
    check("async_rst_mic_clk", int'(mic_clk_out), 0);
    check("async_rst_sample", int'(sample_out), 0);
    check("async_rst_valid", int'(sample_valid_out), 0);
    repeat (2) @(negedge clk_in);
    push(K_ANY, 0);
    rst_in = 1'b0;
    n = 0;
    for (int i = 0; i < FRAME + 100; i++) begin
      @(posedge clk_in);
      #1;
      n++;
      if (sample_valid_out) break;
    end
    check("first_valid_after_reset", n, FRAME + LAT);

`ifdef PDM_DCBLOCK_EN
    run_pattern(4'b0000, "drain_const0", K_LT, -16000, K_INC, 0);
    run_pattern(4'b0101, "drain_alt", K_ANY, 0, K_ANY, 0);
    run_pattern(4'b0001, "drain_1000", K_ANY, 0, K_ANY, 0);
`else
    run_pattern(4'b0000, "drain_const0", K_EQ, -32768, K_EQ, -32768);
    run_pattern(4'b0101, "drain_alt", K_EQ, 0, K_EQ, 0);
    run_pattern(4'b0001, "drain_1000", K_EQ, -16384, K_EQ, -16384);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
